// File: rtl/ws281x_frame_sched_if.sv
// ----------------------------------------------------------------------------
// ws281x_frame_sched_if
//   Bundles the pixel-RAM read port and the per-driver prefetch ports used by
//   ws281x_frame_sched.
//
//   master : the frame scheduler (drives mem_req/mem_addr and the port_* data)
//   slave  : the RAM + driver side (drives mem_ack/mem_rdata and port_rd)
//
// Handshake semantics:
//   RAM read  : mem_req is held high with a stable mem_addr until the clock
//               edge on which mem_ack is high; mem_ack is a single-cycle pulse
//               carrying mem_rdata and is ignored while mem_req is low.
//   Driver    : port_dval[i] high means port_data[i] holds an unconsumed word;
//               a single-cycle port_rd[i] while port_dval[i] is high consumes
//               it (dval drops on the next edge); port_rd[i] while
//               port_dval[i] is low has no effect.
// ----------------------------------------------------------------------------
interface ws281x_frame_sched_if #(
    parameter int NPORT = 2,
    parameter int AW    = 8
);
    logic                  mem_req;
    logic [AW-1:0]         mem_addr;
    logic                  mem_ack;
    logic [23:0]           mem_rdata;
    logic [NPORT-1:0]      port_enb;
    logic [NPORT-1:0]      port_dval;
    logic [NPORT*24-1:0]   port_data;
    logic [NPORT-1:0]      port_rd;

    modport master (
        output mem_req, mem_addr, port_enb, port_dval, port_data,
        input  mem_ack, mem_rdata, port_rd
    );

    modport slave (
        input  mem_req, mem_addr, port_enb, port_dval, port_data,
        output mem_ack, mem_rdata, port_rd
    );
endinterface

// File: rtl/ws281x_frame_sched.sv
// ----------------------------------------------------------------------------
// ws281x_frame_sched
//   Frame scheduler between the register block and the ws281x drivers. On a
//   frame start every port with a non-zero pixel count streams that many
//   24-bit GRB words from the shared pixel RAM, starting at its base address.
//   A round-robin arbiter serialises RAM reads into one prefetch register per
//   port. In auto mode a refresh timer retriggers the next frame.
//
// Ports:
//   mclk, h_reset_n         clock, asynchronous active-low reset
//   cfg_start               single-cycle frame start request
//   cfg_auto                auto-refresh enable
//   cfg_refresh_period      idle clocks between frames in auto mode
//   cfg_base_addr           per-port start address, port i at [i*AW +: AW]
//   cfg_pix_cnt             per-port pixel count, port i at [i*PW +: PW]
//   cfg_bright              brightness scale (only with WS281X_BRIGHTNESS_EN)
//   bus                     RAM read port + driver prefetch ports (master)
//   frame_busy, frame_done  frame status / single-cycle completion pulse
//   dbg_state               FSM state: 0 IDLE, 1 ARB, 2 FETCH, 3 DONE, 4 WAIT
//
// Build option:
//   WS281X_BRIGHTNESS_EN    adds cfg_bright; each captured byte c is stored
//                           as (c * (cfg_bright + 1)) >> 8.
// ----------------------------------------------------------------------------
module ws281x_frame_sched #(
    parameter int NPORT = 2,
    parameter int AW    = 8,
    parameter int PW    = 8
) (
    input  logic                  mclk,
    input  logic                  h_reset_n,
    input  logic                  cfg_start,
    input  logic                  cfg_auto,
    input  logic [23:0]           cfg_refresh_period,
    input  logic [NPORT*AW-1:0]   cfg_base_addr,
    input  logic [NPORT*PW-1:0]   cfg_pix_cnt,
`ifdef WS281X_BRIGHTNESS_EN
    input  logic [7:0]            cfg_bright,
`endif
    ws281x_frame_sched_if.master  bus,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic [2:0]            dbg_state
);
    localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_FETCH = 3'd2,
        S_DONE  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [AW-1:0]       r_next_addr [NPORT];
    logic [PW-1:0]       r_remain    [NPORT];
    logic [23:0]         r_data      [NPORT];
    logic [NPORT-1:0]    r_dval, r_enb;
    logic [GW-1:0]       r_grant, r_rr_ptr;
    logic                r_busy;
    logic [23:0]         r_refresh;

    logic [NPORT-1:0]    w_rem_nz, w_elig;
    logic [GW-1:0]       w_pick, w_idx, w_ptr_nxt;
    logic                w_any_elig, w_start, w_expire, w_ack_fire;
    logic [23:0]         w_capture;
    logic                w_mem_req;
    logic [AW-1:0]       w_mem_addr;
    logic [NPORT*24-1:0] w_port_data;

    // A port may be fetched for when it still owes words and its prefetch
    // register is empty.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_rem_nz[i] = (r_remain[i] != '0);
            w_elig[i]   = w_rem_nz[i] & ~r_dval[i];
        end
    end

    // Round-robin: search starts at r_rr_ptr (the port after the last grant).
    // Scanning from the far end lets the nearest eligible port win.
    always_comb begin
        w_any_elig = 1'b0;
        w_pick     = r_rr_ptr;
        w_idx      = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            w_idx = GW'((int'(r_rr_ptr) + k) % NPORT);
            if (w_elig[w_idx]) begin
                w_any_elig = 1'b1;
                w_pick     = w_idx;
            end
        end
        w_ptr_nxt = GW'((int'(w_pick) + 1) % NPORT);
    end

    // Timer expires on the clock its count steps down to zero.
    assign w_expire   = (r_refresh <= 24'd1);
    assign w_ack_fire = (r_state == S_FETCH) && bus.mem_ack;
    assign w_start    = ((r_state == S_IDLE) || (r_state == S_WAIT))
                        && (w_state_nxt == S_ARB);

`ifdef WS281X_BRIGHTNESS_EN
    logic [8:0]  w_gain;
    logic [16:0] w_prod [3];
    always_comb begin
        w_gain    = {1'b0, cfg_bright} + 9'd1;
        w_capture = '0;
        for (int b = 0; b < 3; b++) begin
            w_prod[b] = {9'd0, bus.mem_rdata[8*b +: 8]} * {8'd0, w_gain};
            w_capture[8*b +: 8] = w_prod[b][15:8];
        end
    end
`else
    assign w_capture = bus.mem_rdata;
`endif

    // FSM: state register
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cfg_start) w_state_nxt = S_ARB;
            S_ARB: begin
                if (w_any_elig)
                    w_state_nxt = S_FETCH;
                else if ((w_rem_nz == '0) && (r_dval == '0))
                    w_state_nxt = S_DONE;
            end
            S_FETCH: if (bus.mem_ack) w_state_nxt = S_ARB;
            S_DONE:  w_state_nxt = cfg_auto ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (cfg_start || (cfg_auto && w_expire))
                    w_state_nxt = S_ARB;
                else if (!cfg_auto)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_mem_req  = 1'b0;
        w_mem_addr = '0;
        frame_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_next_addr[r_grant];
            end
            S_DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: frame latch, grant, prefetch registers, refresh timer
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            r_busy    <= 1'b0;
            r_enb     <= '0;
            r_dval    <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_refresh <= '0;
            for (int i = 0; i < NPORT; i++) begin
                r_next_addr[i] <= '0;
                r_remain[i]    <= '0;
                r_data[i]      <= '0;
            end
        end else begin
            if (w_start) begin
                r_busy <= 1'b1;
                for (int i = 0; i < NPORT; i++) begin
                    r_next_addr[i] <= cfg_base_addr[i*AW +: AW];
                    r_remain[i]    <= cfg_pix_cnt[i*PW +: PW];
                    r_enb[i]       <= (cfg_pix_cnt[i*PW +: PW] != '0);
                end
            end
            if ((r_state == S_ARB) && w_any_elig) begin
                r_grant  <= w_pick;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == S_DONE) begin
                r_busy    <= 1'b0;
                r_enb     <= '0;
                r_refresh <= cfg_refresh_period;
            end
            if ((r_state == S_WAIT) && (r_refresh != '0))
                r_refresh <= r_refresh - 24'd1;
            // An ack only ever targets an empty register, so it never races
            // a consume on the same port.
            for (int i = 0; i < NPORT; i++) begin
                if (w_ack_fire && (r_grant == GW'(i))) begin
                    r_data[i]      <= w_capture;
                    r_dval[i]      <= 1'b1;
                    r_next_addr[i] <= r_next_addr[i] + AW'(1);
                    r_remain[i]    <= r_remain[i] - PW'(1);
                end else if (bus.port_rd[i]) begin
                    r_dval[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_port_data = '0;
        for (int i = 0; i < NPORT; i++)
            w_port_data[i*24 +: 24] = r_data[i];
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.port_enb  = r_enb;
    assign bus.port_dval = r_dval;
    assign bus.port_data = w_port_data;
    assign frame_busy    = r_busy;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_ws281x_frame_sched.sv
module tb_ws281x_frame_sched;
  localparam int NPORT = 2;
  localparam int AW = 8;
  localparam int PW = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd4;

  logic mclk, h_reset_n, cfg_start, cfg_auto;
  logic [23:0] cfg_refresh_period;
  logic [NPORT*AW-1:0] cfg_base_addr;
  logic [NPORT*PW-1:0] cfg_pix_cnt;
`ifdef WS281X_BRIGHTNESS_EN
  logic [7:0] cfg_bright;
`endif
  logic frame_busy, frame_done;
  logic [2:0] dbg_state;

  ws281x_frame_sched_if #(.NPORT(NPORT), .AW(AW)) bus ();

  ws281x_frame_sched #(.NPORT(NPORT), .AW(AW), .PW(PW)) dut (
    .mclk(mclk),
    .h_reset_n(h_reset_n),
    .cfg_start(cfg_start),
    .cfg_auto(cfg_auto),
    .cfg_refresh_period(cfg_refresh_period),
    .cfg_base_addr(cfg_base_addr),
    .cfg_pix_cnt(cfg_pix_cnt),
`ifdef WS281X_BRIGHTNESS_EN
    .cfg_bright(cfg_bright),
`endif
    .bus(bus),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];   // expected RAM read addresses, in order
  logic [23:0] exp_d0[$];    // expected words consumed by driver 0
  logic [23:0] exp_d1[$];    // expected words consumed by driver 1
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ram_word(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h3C};
  endfunction

  // ---------------- environment: RAM, drivers, monitors ----------------
  int done_cnt = 0, done_cyc = 0, req_rise_cyc = 0, last_rd_cyc = 0;
  int n_reads = 0, lat_cnt = 0, ram_lat = 1;
  int rd_delay[2];
  int wcnt[2];
  bit stray_ack = 0, ram_force = 0, req_prev = 0, enb_seen = 0;
  logic [23:0] ram_force_val = '0;

  task automatic env_step();
    logic [NPORT-1:0] rd_v;
    logic [23:0] got;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.port_enb != '0) enb_seen = 1;
    if (bus.mem_req && !req_prev) req_rise_cyc = cyc;
    req_prev = bus.mem_req;
    // RAM model
    bus.mem_ack = 1'b0;
    if (stray_ack) begin
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 24'h123456;
      stray_ack = 0;
    end else if (h_reset_n && bus.mem_req) begin
      if (lat_cnt >= ram_lat) begin
        lat_cnt = 0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = ram_force ? ram_force_val : ram_word(bus.mem_addr);
        n_reads++;
        check_eq("rd_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("rd_addr", bus.mem_addr, exp_q.pop_front());
      end else lat_cnt++;
    end else lat_cnt = 0;
    // driver models
    rd_v = '0;
    for (int i = 0; i < 2; i++) begin
      if (bus.port_dval[i] && rd_delay[i] >= 0) begin
        if (wcnt[i] >= rd_delay[i]) begin
          rd_v[i] = 1'b1;
          wcnt[i] = 0;
          last_rd_cyc = cyc;
          got = bus.port_data[i*24 +: 24];
          if (i == 0) begin
            check_eq("d0_expected", exp_d0.size() != 0, 1);
            if (exp_d0.size() != 0) check_eq("d0_data", got, exp_d0.pop_front());
          end else begin
            check_eq("d1_expected", exp_d1.size() != 0, 1);
            if (exp_d1.size() != 0) check_eq("d1_data", got, exp_d1.pop_front());
          end
        end else wcnt[i]++;
      end else wcnt[i] = 0;
    end
    bus.port_rd = rd_v;
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.port_rd = '0;
    forever begin
      @(negedge mclk);
      env_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    h_reset_n = 1'b0;
    cfg_start = 1'b0;
    cfg_auto = 1'b0;
    cfg_refresh_period = '0;
    cfg_base_addr = '0;
    cfg_pix_cnt = '0;
`ifdef WS281X_BRIGHTNESS_EN
    cfg_bright = 8'hFF;
`endif
    exp_q.delete();
    exp_d0.delete();
    exp_d1.delete();
    rd_delay[0] = 0;
    rd_delay[1] = 0;
    ram_lat = 1;
    ram_force = 0;
    repeat (3) @(negedge mclk);
    h_reset_n = 1'b1;
    @(negedge mclk);
  endtask

  task automatic start_frame(input string tag);
    cfg_start = 1'b1;
    @(negedge mclk);
    cfg_start = 1'b0;
    check_eq({tag, "_busy_next"}, frame_busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge mclk);
      n++;
    end
    check_eq({tag, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic push_port(input int p, input logic [AW-1:0] base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (p == 0) exp_d0.push_back(ram_word(base + AW'(k)));
      else        exp_d1.push_back(ram_word(base + AW'(k)));
    end
  endtask

  // ---------------- tests ----------------
  initial begin
    int d0, rd0, n, gap, st;
    h_reset_n = 1'b0;
    do_reset();

    // reset state
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_port_enb", bus.port_enb, 0);
    check_eq("rst_port_dval", bus.port_dval, 0);
    check_eq("rst_port_data_zero", bus.port_data == '0, 1);
    check_eq("rst_busy", frame_busy, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);

    // single port, slow driver
    do_reset();
    cfg_base_addr = {8'h00, 8'h10};
    cfg_pix_cnt = {8'd0, 8'd3};
    rd_delay[0] = 5;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    push_port(0, 8'h10, 3);
    d0 = done_cnt;
    start_frame("t1");
    check_eq("t1_port_enb", bus.port_enb, 2'b01);
    wait_done("t1", 300);
    check_eq("t1_done_after_consume", done_cyc > last_rd_cyc, 1);
    repeat (20) @(negedge mclk);
    check_eq("t1_done_once", done_cnt - d0, 1);
    check_eq("t1_reads_left", exp_q.size(), 0);
    check_eq("t1_words_left", exp_d0.size(), 0);
    check_eq("t1_enb_after", bus.port_enb, 0);
    check_eq("t1_busy_after", frame_busy, 0);

    // two ports, instant drivers, cfg changed mid-frame
    do_reset();
    cfg_base_addr = {8'h80, 8'h00};
    cfg_pix_cnt = {8'd2, 8'd2};
    exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    exp_q.push_back(8'h01); exp_q.push_back(8'h81);
    push_port(0, 8'h00, 2);
    push_port(1, 8'h80, 2);
    start_frame("t2");
    check_eq("t2_port_enb", bus.port_enb, 2'b11);
    cfg_pix_cnt = '0;
    cfg_base_addr = '1;
    wait_done("t2", 300);
    check_eq("t2_reads_left", exp_q.size(), 0);
    check_eq("t2_w0_left", exp_d0.size(), 0);
    check_eq("t2_w1_left", exp_d1.size(), 0);

    // backpressure on port 0
    do_reset();
    cfg_base_addr = {8'h80, 8'h00};
    cfg_pix_cnt = {8'd4, 8'd4};
    rd_delay[0] = -1;
    exp_q.push_back(8'h00);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h80 + 8'(k));
    push_port(1, 8'h80, 4);
    d0 = done_cnt;
    rd0 = n_reads;
    start_frame("t3");
    repeat (100) @(negedge mclk);
    check_eq("t3_reads", n_reads - rd0, 5);
    check_eq("t3_reads_left", exp_q.size(), 0);
    check_eq("t3_w1_left", exp_d1.size(), 0);
    check_eq("t3_busy", frame_busy, 1);
    check_eq("t3_no_done", done_cnt - d0, 0);
    check_eq("t3_dval0", bus.port_dval[0], 1);
    check_eq("t3_data0", bus.port_data[23:0], ram_word(8'h00));

    // auto refresh
    do_reset();
    cfg_base_addr = {8'h00, 8'h20};
    cfg_pix_cnt = {8'd0, 8'd1};
    cfg_auto = 1'b1;
    cfg_refresh_period = 24'd100;
    exp_q.push_back(8'h20);
    push_port(0, 8'h20, 1);
    start_frame("t4");
    wait_done("t4_f1", 100);
    rd0 = n_reads;
    exp_q.push_back(8'h20);
    push_port(0, 8'h20, 1);
    n = 0;
    while (n_reads == rd0 && n < 200) begin
      @(negedge mclk);
      n++;
    end
    check_eq("t4_refresh_read", n_reads != rd0, 1);
    gap = req_rise_cyc - done_cyc;
    check_eq("t4_gap_100_to_102", (gap >= 100) && (gap <= 102), 1);
    wait_done("t4_f2", 50);
    repeat (20) @(negedge mclk);
    check_eq("t4_waiting", dbg_state, ST_WAIT);
    cfg_auto = 1'b0;
    repeat (2) @(negedge mclk);
    check_eq("t4_idle", dbg_state, ST_IDLE);
    d0 = done_cnt;
    rd0 = n_reads;
    repeat (150) @(negedge mclk);
    check_eq("t4_no_new_reads", n_reads - rd0, 0);
    check_eq("t4_no_new_done", done_cnt - d0, 0);
    check_eq("t4_busy", frame_busy, 0);

    // stray ack, zero-count frame, ignored start while busy
    do_reset();
    stray_ack = 1;
    repeat (2) @(negedge mclk);
    check_eq("t5_stray_dval", bus.port_dval, 0);
    check_eq("t5_stray_state", dbg_state, ST_IDLE);
    enb_seen = 0;
    d0 = done_cnt;
    st = cyc;
    start_frame("t5z");
    wait_done("t5z", 10);
    check_eq("t5z_within_3", (done_cyc - st) <= 3, 1);
    check_eq("t5z_enb_never", enb_seen, 0);
    repeat (5) @(negedge mclk);
    check_eq("t5z_done_once", done_cnt - d0, 1);
    cfg_base_addr = {8'h00, 8'h40};
    cfg_pix_cnt = {8'd0, 8'd3};
    rd_delay[0] = 5;
    for (int k = 0; k < 3; k++) exp_q.push_back(8'h40 + 8'(k));
    push_port(0, 8'h40, 3);
    d0 = done_cnt;
    rd0 = n_reads;
    start_frame("t5b");
    repeat (5) @(negedge mclk);
    cfg_start = 1'b1;
    @(negedge mclk);
    cfg_start = 1'b0;
    wait_done("t5b", 300);
    repeat (40) @(negedge mclk);
    check_eq("t5b_done_once", done_cnt - d0, 1);
    check_eq("t5b_reads", n_reads - rd0, 3);
    check_eq("t5b_reads_left", exp_q.size(), 0);

    // reset during FETCH
    do_reset();
    ram_lat = 8;
    cfg_pix_cnt = {8'd0, 8'd2};
    start_frame("t6");
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge mclk);
      n++;
    end
    check_eq("t6_in_fetch", bus.mem_req, 1);
    h_reset_n = 1'b0;
    #1;
    check_eq("t6_req_async", bus.mem_req, 0);
    check_eq("t6_addr", bus.mem_addr, 0);
    check_eq("t6_enb", bus.port_enb, 0);
    check_eq("t6_busy", frame_busy, 0);
    check_eq("t6_state", dbg_state, ST_IDLE);
    do_reset();
    repeat (5) @(negedge mclk);
    check_eq("t6_idle_req", bus.mem_req, 0);

`ifdef WS281X_BRIGHTNESS_EN
    // brightness scaling
    do_reset();
    cfg_bright = 8'h7F;
    ram_force = 1;
    ram_force_val = 24'hFF8002;
    cfg_pix_cnt = {8'd0, 8'd1};
    exp_q.push_back(8'h00);
    exp_d0.push_back(24'h7F4001);
    start_frame("t7");
    wait_done("t7", 50);
    check_eq("t7_words_left", exp_d0.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
